// File: rtl/j17_pkg.sv
// -----------------------------------------------------------------------------
// j17_pkg
// Shared definitions for the J17 multi-cycle control unit: opcode values,
// ALU operation codes, PC-select codes, fault codes, FSM state and opcode
// class enums, and the bundle of registered control outputs.
// -----------------------------------------------------------------------------
package j17_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd2;
    localparam logic [5:0] OP_DIV  = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_SUBI = 6'd5;
    localparam logic [5:0] OP_MULI = 6'd6;
    localparam logic [5:0] OP_DIVI = 6'd7;
    localparam logic [5:0] OP_NOT  = 6'd8;
    localparam logic [5:0] OP_AND  = 6'd9;
    localparam logic [5:0] OP_OR   = 6'd10;
    localparam logic [5:0] OP_XOR  = 6'd11;
    localparam logic [5:0] OP_MOD  = 6'd12;
    localparam logic [5:0] OP_SL   = 6'd13;
    localparam logic [5:0] OP_SR   = 6'd14;
    localparam logic [5:0] OP_JE   = 6'd15;
    localparam logic [5:0] OP_JB   = 6'd16;
    localparam logic [5:0] OP_JA   = 6'd17;
    localparam logic [5:0] OP_JNE  = 6'd18;
    localparam logic [5:0] OP_JBE  = 6'd19;
    localparam logic [5:0] OP_JAE  = 6'd20;
    localparam logic [5:0] OP_JNZ  = 6'd21;
    localparam logic [5:0] OP_JZ   = 6'd22;
    localparam logic [5:0] OP_JMP  = 6'd23;
    localparam logic [5:0] OP_MOV  = 6'd24;
    localparam logic [5:0] OP_NOP  = 6'd25;
    localparam logic [5:0] OP_HLT  = 6'd26;
    localparam logic [5:0] OP_PUSH = 6'd27;
    localparam logic [5:0] OP_POP  = 6'd28;
    localparam logic [5:0] OP_MOVI = 6'd29;

    // ALU operation codes
    localparam logic [5:0] ALU_NONE = 6'd0;
    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_MUL  = 6'd3;
    localparam logic [5:0] ALU_DIV  = 6'd4;
    localparam logic [5:0] ALU_MOD  = 6'd5;
    localparam logic [5:0] ALU_OR   = 6'd6;
    localparam logic [5:0] ALU_AND  = 6'd7;
    localparam logic [5:0] ALU_NOT  = 6'd9;
    localparam logic [5:0] ALU_SR   = 6'd10;
    localparam logic [5:0] ALU_XOR  = 6'd11;
    localparam logic [5:0] ALU_SL   = 6'd12;
    localparam logic [5:0] ALU_PASS = 6'd14;

    // PC select codes
    localparam logic [4:0] PC_NEXT = 5'd0;
    localparam logic [4:0] PC_JE   = 5'd1;
    localparam logic [4:0] PC_JB   = 5'd2;
    localparam logic [4:0] PC_JA   = 5'd3;
    localparam logic [4:0] PC_JNE  = 5'd4;
    localparam logic [4:0] PC_JBE  = 5'd5;
    localparam logic [4:0] PC_JAE  = 5'd6;
    localparam logic [4:0] PC_JNZ  = 5'd7;
    localparam logic [4:0] PC_JZ   = 5'd8;
    localparam logic [4:0] PC_JMP  = 5'd9;
    localparam logic [4:0] PC_HALT = 5'd10;

    // Stack datapath mux
    localparam logic [1:0] STK_NONE = 2'd0;
    localparam logic [1:0] STK_PUSH = 2'd1;
    localparam logic [1:0] STK_POP  = 2'd2;

    // Fault codes
    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STACK = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // How the FSM sequences an opcode once it reaches EXEC
    typedef enum logic [2:0] {
        CL_SINGLE  = 3'd0,
        CL_MULTI   = 3'd1,
        CL_PUSH    = 3'd2,
        CL_POP     = 3'd3,
        CL_HALT    = 3'd4,
        CL_ILLEGAL = 3'd5
    } op_class_t;

    // Registered control outputs, updated together once per cycle
    typedef struct packed {
        logic [5:0] alucode;
        logic       imm_sel;
        logic       reg_write;
        logic [4:0] pc_ctrl;
        logic [1:0] stack_sel;
        logic       alu_start;
        logic       retire;
        logic       halted;
        logic [1:0] fault_code;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Opcodes above MOVI have no defined meaning
    function automatic logic is_illegal(input logic [5:0] opc);
        return (opc > OP_MOVI);
    endfunction

endpackage

// File: rtl/j17_control_fsm_decode.sv
// -----------------------------------------------------------------------------
// j17_decode
// Pure combinational opcode decoder for the J17 control unit.
// Ports:
//   opcode    in  6  instruction bits [31:26]
//   alucode   out 6  ALU operation
//   imm_sel   out 1  operand B taken from the immediate field
//   reg_write out 1  register write for single-cycle retirement
//   pc_ctrl   out 5  PC select for the EXEC cycle
//   op_class  out 3  sequencing class used by the FSM
// -----------------------------------------------------------------------------
module j17_decode
    import j17_pkg::*;
(
    input  logic [5:0]  opcode,
    output logic [5:0]  alucode,
    output logic        imm_sel,
    output logic        reg_write,
    output logic [4:0]  pc_ctrl,
    output op_class_t   op_class
);

    // Opcode to control-field lookup
    always_comb begin
        alucode   = ALU_NONE;
        imm_sel   = 1'b0;
        reg_write = 1'b0;
        pc_ctrl   = PC_NEXT;
        op_class  = CL_SINGLE;
        case (opcode)
            OP_ADD:  begin alucode = ALU_ADD; reg_write = 1'b1; end
            OP_ADDI: begin alucode = ALU_ADD; reg_write = 1'b1; imm_sel = 1'b1; end
            OP_SUB:  begin alucode = ALU_SUB; reg_write = 1'b1; end
            OP_SUBI: begin alucode = ALU_SUB; reg_write = 1'b1; imm_sel = 1'b1; end
            OP_MUL:  begin alucode = ALU_MUL; reg_write = 1'b1; op_class = CL_MULTI; end
            OP_MULI: begin alucode = ALU_MUL; reg_write = 1'b1; imm_sel = 1'b1; op_class = CL_MULTI; end
            OP_DIV:  begin alucode = ALU_DIV; reg_write = 1'b1; op_class = CL_MULTI; end
            OP_DIVI: begin alucode = ALU_DIV; reg_write = 1'b1; imm_sel = 1'b1; op_class = CL_MULTI; end
            OP_MOD:  begin alucode = ALU_MOD; reg_write = 1'b1; op_class = CL_MULTI; end
            OP_OR:   begin alucode = ALU_OR;  reg_write = 1'b1; end
            OP_AND:  begin alucode = ALU_AND; reg_write = 1'b1; end
            OP_NOT:  begin alucode = ALU_NOT; reg_write = 1'b1; end
            OP_SR:   begin alucode = ALU_SR;  reg_write = 1'b1; end
            OP_XOR:  begin alucode = ALU_XOR; reg_write = 1'b1; end
            OP_SL:   begin alucode = ALU_SL;  reg_write = 1'b1; end
            OP_JE:   begin alucode = ALU_PASS; pc_ctrl = PC_JE;  end
            OP_JB:   begin alucode = ALU_PASS; pc_ctrl = PC_JB;  end
            OP_JA:   begin alucode = ALU_PASS; pc_ctrl = PC_JA;  end
            OP_JNE:  begin alucode = ALU_PASS; pc_ctrl = PC_JNE; end
            OP_JBE:  begin alucode = ALU_PASS; pc_ctrl = PC_JBE; end
            OP_JAE:  begin alucode = ALU_PASS; pc_ctrl = PC_JAE; end
            OP_JNZ:  begin alucode = ALU_PASS; pc_ctrl = PC_JNZ; end
            OP_JZ:   begin alucode = ALU_PASS; pc_ctrl = PC_JZ;  end
            OP_JMP:  begin alucode = ALU_PASS; pc_ctrl = PC_JMP; end
            OP_MOV:  begin alucode = ALU_PASS; reg_write = 1'b1; end
            OP_MOVI: begin alucode = ALU_PASS; reg_write = 1'b1; imm_sel = 1'b1; end
            OP_NOP:  begin alucode = ALU_NONE; end
            OP_HLT:  begin pc_ctrl = PC_HALT; op_class = CL_HALT; end
            OP_PUSH: begin op_class = CL_PUSH; end
            OP_POP:  begin op_class = CL_POP; end
            default: begin
                // Covers 30..63; is_illegal() keeps the intent visible
                if (is_illegal(opcode)) begin
                    pc_ctrl  = PC_HALT;
                    op_class = CL_ILLEGAL;
                end else begin
                    pc_ctrl  = PC_NEXT;
                    op_class = CL_SINGLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/j17_control_fsm.sv
// -----------------------------------------------------------------------------
// j17_control_fsm
// Multi-cycle control unit for the J17 core. Accepts an instruction over a
// valid/ready handshake, holds it in an instruction register and sequences it
// through EXEC and, where needed, WAIT (multi-cycle ALU) or STACK. Owns a
// bounded stack pointer and reports halt / fault status.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   instr, instr_valid    instruction from fetch and its valid
//   instr_ready           high only while in FETCH
//   alu_done              multi-cycle ALU result ready (used only in WAIT)
//   alu_start             one-cycle launch pulse for MUL/DIV/MOD
//   alucode, imm_sel      ALU operation and operand B select
//   reg_write, pc_ctrl    register write enable and PC select
//   stack_sel, sp         stack mux select and stack pointer
//   op1, op2, flag, flag1 instruction register field slices
//   retire                one-cycle completion pulse
//   halted, fault_code    sticky halt flag and fault reason
// Control outputs are registered: each cycle's values are computed from the
// transition being taken, so they are valid for the whole of the state they
// describe (e.g. the EXEC decode is visible in the EXEC cycle itself).
// -----------------------------------------------------------------------------
module j17_control_fsm
    import j17_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int OPC_W          = 6,
    parameter int STACK_DEPTH    = 16,
    parameter int MULTICYCLE_ALU = 1,
    localparam int SP_W          = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              alu_done,
    output logic              alu_start,
    output logic [5:0]        alucode,
    output logic              imm_sel,
    output logic              reg_write,
    output logic [4:0]        pc_ctrl,
    output logic [1:0]        stack_sel,
    output logic [SP_W-1:0]   sp,
    output logic [2:0]        op1,
    output logic [20:0]       op2,
    output logic              flag,
    output logic              flag1,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        fault_code
);

    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_EMPTY = {SP_W{1'b0}};
    localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);

    state_t            state_r;
    state_t            next_state_s;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] ir_next_s;
    logic [SP_W-1:0]   sp_r;
    logic [SP_W-1:0]   sp_next_s;
    ctrl_t             ctrl_r;
    ctrl_t             ctrl_next_s;
    logic              ready_r;
    logic              multi_s;

    logic [5:0]        dec_alucode_s;
    logic              dec_imm_sel_s;
    logic              dec_reg_write_s;
    logic [4:0]        dec_pc_ctrl_s;
    op_class_t         dec_class_s;

    // The decoder looks at the word that EXEC will see: the incoming
    // instruction on an accepting FETCH cycle, otherwise the held ir.
    always_comb begin
        if ((state_r == ST_FETCH) && instr_valid) begin
            ir_next_s = instr;
        end else begin
            ir_next_s = ir_r;
        end
    end

    j17_decode u_decode (
        .opcode    (ir_next_s[DATA_W-1 -: OPC_W]),
        .alucode   (dec_alucode_s),
        .imm_sel   (dec_imm_sel_s),
        .reg_write (dec_reg_write_s),
        .pc_ctrl   (dec_pc_ctrl_s),
        .op_class  (dec_class_s)
    );

    // State, instruction, stack pointer and control output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH;
            ir_r    <= {DATA_W{1'b0}};
            sp_r    <= SP_EMPTY;
            ctrl_r  <= CTRL_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            ir_r    <= ir_next_s;
            sp_r    <= sp_next_s;
            ctrl_r  <= ctrl_next_s;
            ready_r <= (next_state_s == ST_FETCH);
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (instr_valid) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (dec_class_s)
                    CL_SINGLE:  next_state_s = ST_FETCH;
                    CL_MULTI:   next_state_s = (MULTICYCLE_ALU != 0) ? ST_WAIT : ST_FETCH;
                    CL_PUSH:    next_state_s = ST_STACK;
                    CL_POP:     next_state_s = ST_STACK;
                    CL_HALT:    next_state_s = ST_HALT;
                    CL_ILLEGAL: next_state_s = ST_HALT;
                    default:    next_state_s = ST_FETCH;
                endcase
            end
            ST_WAIT: begin
                if (alu_done) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_STACK: begin
                // The fault (if any) was latched on entry to STACK
                if (ctrl_r.fault_code != FAULT_NONE) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_FETCH;
        endcase
    end

    // Control outputs and stack pointer for the cycle being entered
    always_comb begin
        ctrl_next_s = ctrl_r;
        sp_next_s   = sp_r;
        multi_s     = (dec_class_s == CL_MULTI) && (MULTICYCLE_ALU != 0);
        case (state_r)
            ST_FETCH: begin
                ctrl_next_s = CTRL_IDLE;
                if (instr_valid) begin
                    ctrl_next_s.alucode   = dec_alucode_s;
                    ctrl_next_s.imm_sel   = dec_imm_sel_s;
                    ctrl_next_s.pc_ctrl   = dec_pc_ctrl_s;
                    // A multi-cycle op writes back only once alu_done arrives
                    ctrl_next_s.reg_write = dec_reg_write_s && !multi_s;
                    ctrl_next_s.alu_start = multi_s;
                    ctrl_next_s.retire    = (dec_class_s == CL_SINGLE) ||
                                            ((dec_class_s == CL_MULTI) && !multi_s);
                    ctrl_next_s.halted    = (dec_class_s == CL_HALT);
                    ctrl_next_s.fault_code = (dec_class_s == CL_ILLEGAL) ? FAULT_ILLEGAL
                                                                         : FAULT_NONE;
                end else begin
                    ctrl_next_s.alucode = ALU_NONE;
                end
            end
            ST_EXEC: begin
                if (next_state_s == ST_WAIT) begin
                    ctrl_next_s.alu_start = 1'b0;
                end else if (next_state_s == ST_STACK) begin
                    ctrl_next_s         = CTRL_IDLE;
                    ctrl_next_s.alucode = ctrl_r.alucode;
                    ctrl_next_s.imm_sel = ctrl_r.imm_sel;
                    if (dec_class_s == CL_PUSH) begin
                        if (sp_r == SP_FULL) begin
                            ctrl_next_s.fault_code = FAULT_OVERFLOW;
                        end else begin
                            ctrl_next_s.stack_sel = STK_PUSH;
                            ctrl_next_s.retire    = 1'b1;
                            sp_next_s             = sp_r + SP_ONE;
                        end
                    end else begin
                        if (sp_r == SP_EMPTY) begin
                            ctrl_next_s.fault_code = FAULT_UNDERFLOW;
                        end else begin
                            ctrl_next_s.stack_sel = STK_POP;
                            ctrl_next_s.reg_write = 1'b1;
                            ctrl_next_s.retire    = 1'b1;
                            sp_next_s             = sp_r - SP_ONE;
                        end
                    end
                end else if (next_state_s == ST_FETCH) begin
                    ctrl_next_s = CTRL_IDLE;
                end else begin
                    // Entering HALT: freeze what EXEC showed
                    ctrl_next_s = ctrl_r;
                end
            end
            ST_WAIT: begin
                if (alu_done) begin
                    ctrl_next_s.retire    = 1'b1;
                    ctrl_next_s.reg_write = 1'b1;
                    ctrl_next_s.alu_start = 1'b0;
                end else begin
                    ctrl_next_s = ctrl_r;
                end
            end
            ST_STACK: begin
                if (next_state_s == ST_FETCH) begin
                    ctrl_next_s = CTRL_IDLE;
                end else begin
                    ctrl_next_s = ctrl_r;
                end
            end
            ST_HALT:  ctrl_next_s = ctrl_r;
            default:  ctrl_next_s = CTRL_IDLE;
        endcase
    end

    assign instr_ready = ready_r;
    assign alu_start   = ctrl_r.alu_start;
    assign alucode     = ctrl_r.alucode;
    assign imm_sel     = ctrl_r.imm_sel;
    assign reg_write   = ctrl_r.reg_write;
    assign pc_ctrl     = ctrl_r.pc_ctrl;
    assign stack_sel   = ctrl_r.stack_sel;
    assign retire      = ctrl_r.retire;
    assign halted      = ctrl_r.halted;
    assign fault_code  = ctrl_r.fault_code;
    assign sp          = sp_r;

    // Field slices of the held instruction
    assign op1   = ir_r[24:22];
    assign op2   = ir_r[20:0];
    assign flag  = ir_r[25];
    assign flag1 = ir_r[21];

endmodule

// File: tb/tb_j17_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_j17_control_fsm
// Directed self-checking bench for j17_control_fsm. Inputs change and outputs
// are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_j17_control_fsm;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_done;
    logic        alu_start;
    logic [5:0]  alucode;
    logic        imm_sel;
    logic        reg_write;
    logic [4:0]  pc_ctrl;
    logic [1:0]  stack_sel;
    logic [4:0]  sp;
    logic [2:0]  op1;
    logic [20:0] op2;
    logic        flag;
    logic        flag1;
    logic        retire;
    logic        halted;
    logic [1:0]  fault_code;

    int tests = 0;
    int fails = 0;

    j17_control_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_done    (alu_done),
        .alu_start   (alu_start),
        .alucode     (alucode),
        .imm_sel     (imm_sel),
        .reg_write   (reg_write),
        .pc_ctrl     (pc_ctrl),
        .stack_sel   (stack_sel),
        .sp          (sp),
        .op1         (op1),
        .op2         (op2),
        .flag        (flag),
        .flag1       (flag1),
        .retire      (retire),
        .halted      (halted),
        .fault_code  (fault_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        alu_done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Present one instruction for a single accepting cycle; returns in EXEC
    task automatic issue(input logic [31:0] word);
        instr = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'h0;
        instr_valid = 1'b0;
        alu_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_alucode", 32'(alucode), 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault_code), 32'd0);
        chk("rst_pc", 32'(pc_ctrl), 32'd0);

        // ADDI r2,#5
        issue(32'h1080_0005);
        chk("addi_alucode", 32'(alucode), 32'd1);
        chk("addi_imm", 32'(imm_sel), 32'd1);
        chk("addi_rw", 32'(reg_write), 32'd1);
        chk("addi_op1", 32'(op1), 32'd2);
        chk("addi_op2", 32'(op2), 32'd5);
        chk("addi_retire", 32'(retire), 32'd1);
        chk("addi_ready_exec", 32'(instr_ready), 32'd0);
        tick();
        chk("addi_ready_back", 32'(instr_ready), 32'd1);
        chk("addi_retire_drop", 32'(retire), 32'd0);

        // SL must not alias XOR
        issue(32'h3400_0000);
        chk("sl_alucode", 32'(alucode), 32'd12);
        tick();

        // MUL with three WAIT cycles
        issue(32'h0800_0000);
        chk("mul_start", 32'(alu_start), 32'd1);
        chk("mul_alucode", 32'(alucode), 32'd3);
        chk("mul_no_retire", 32'(retire), 32'd0);
        tick();
        chk("mul_start_pulse", 32'(alu_start), 32'd0);
        tick();
        tick();
        chk("mul_wait_ready", 32'(instr_ready), 32'd0);
        chk("mul_wait_retire", 32'(retire), 32'd0);
        chk("mul_wait_alucode", 32'(alucode), 32'd3);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("mul_done_retire", 32'(retire), 32'd1);
        chk("mul_done_rw", 32'(reg_write), 32'd1);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("spur_retire", 32'(retire), 32'd0);
        chk("spur_rw", 32'(reg_write), 32'd0);
        chk("spur_ready", 32'(instr_ready), 32'd1);

        // JZ
        issue(32'h5800_0000);
        chk("jz_pc", 32'(pc_ctrl), 32'd8);
        chk("jz_rw", 32'(reg_write), 32'd0);
        chk("jz_alucode", 32'(alucode), 32'd14);
        tick();
        chk("jz_pc_clear", 32'(pc_ctrl), 32'd0);

        // Fill the stack, then overflow
        for (int i = 0; i < 16; i++) begin
            issue(32'h6C00_0000);
            tick();
            chk("push_sel", 32'(stack_sel), 32'd1);
            chk("push_sp", 32'(sp), 32'(i + 1));
            tick();
        end
        issue(32'h6C00_0000);
        tick();
        chk("ovf_fault", 32'(fault_code), 32'd1);
        chk("ovf_retire", 32'(retire), 32'd0);
        tick();
        chk("ovf_halted", 32'(halted), 32'd0);
        chk("ovf_ready", 32'(instr_ready), 32'd0);
        chk("ovf_sp", 32'(sp), 32'd16);
        issue(32'h1080_0005);
        chk("halt_ignore_valid", 32'(alucode), 32'd0);
        chk("halt_fault_hold", 32'(fault_code), 32'd1);

        // Reset, then POP on empty stack
        do_reset();
        chk("rst2_sp", 32'(sp), 32'd0);
        chk("rst2_fault", 32'(fault_code), 32'd0);
        issue(32'h7000_0000);
        tick();
        chk("udf_fault", 32'(fault_code), 32'd2);
        chk("udf_sp", 32'(sp), 32'd0);
        tick();
        chk("udf_ready", 32'(instr_ready), 32'd0);

        // Illegal opcode
        do_reset();
        issue(32'hFC00_0000);
        chk("ill_fault", 32'(fault_code), 32'd3);
        chk("ill_pc", 32'(pc_ctrl), 32'd10);
        tick();
        chk("ill_pc_hold", 32'(pc_ctrl), 32'd10);
        chk("ill_ready", 32'(instr_ready), 32'd0);

        // HLT
        do_reset();
        issue(32'h6800_0000);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_pc", 32'(pc_ctrl), 32'd10);
        tick();
        chk("hlt_halted_hold", 32'(halted), 32'd1);
        chk("hlt_pc_hold", 32'(pc_ctrl), 32'd10);

        // PUSH then POP, then reset in the middle of a MUL wait
        do_reset();
        issue(32'h6C00_0000);
        tick();
        tick();
        issue(32'h7000_0000);
        tick();
        chk("pop_sel", 32'(stack_sel), 32'd2);
        chk("pop_rw", 32'(reg_write), 32'd1);
        chk("pop_retire", 32'(retire), 32'd1);
        chk("pop_sp", 32'(sp), 32'd0);
        tick();
        issue(32'h6C00_0000);
        tick();
        tick();
        issue(32'h0800_0000);
        tick();
        reset = 1'b1;
        alu_done = 1'b1;
        tick();
        reset = 1'b0;
        alu_done = 1'b0;
        chk("wrst_ready", 32'(instr_ready), 32'd1);
        chk("wrst_retire", 32'(retire), 32'd0);
        chk("wrst_rw", 32'(reg_write), 32'd0);
        chk("wrst_alucode", 32'(alucode), 32'd0);
        chk("wrst_sp", 32'(sp), 32'd0);
        tick();
        chk("wrst_retire_late", 32'(retire), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/j17_control_fsm.md
Name: j17_control_fsm

Overview:
- Multi-cycle control unit for the J17 core; successor to the single-cycle combinational decoder.
- Accepts instructions from fetch over a valid/ready handshake and holds each one in an internal instruction register.
- Sequences FETCH/EXEC/WAIT/STACK states and supports multi-cycle MUL/DIV/MOD ALU handshaking.
- Owns a bounded stack pointer with overflow/underflow detection, and reports halt and fault status.

Parameters:
- DATA_W, 32, instruction width.
- OPC_W, 6, opcode field width, bits [31:26].
- STACK_DEPTH, 16, number of stack entries; SP width is clog2(STACK_DEPTH)+1.
- MULTICYCLE_ALU, 1, when 1, MUL/DIV/MOD wait for alu_done; when 0, they retire like ADD.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr  in  DATA_W  instruction word from fetch
- instr_valid  in  1  instr is valid
- instr_ready  out  1  high only in FETCH
- alu_done  in  1  multi-cycle ALU result ready
- alu_start  out  1  one-cycle pulse launching MUL/DIV/MOD
- alucode  out  6  ALU operation
- imm_sel  out  1  1 = operand B is op2 immediate
- reg_write  out  1  register file write enable
- pc_ctrl  out  5  PC select
- stack_sel  out  2  stack datapath mux (0 none, 1 push, 2 pop)
- sp  out  clog2(STACK_DEPTH)+1  stack pointer
- op1  out  3  ir[24:22]
- op2  out  21  ir[20:0]
- flag  out  1  ir[25]
- flag1  out  1  ir[21]
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  sticky halt
- fault_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 illegal opcode

Behaviour:
- Reset (synchronous, dominates all other events):
  - state = FETCH, ir = 0, sp = 0.
  - All registered outputs are 0: alucode, imm_sel, reg_write, pc_ctrl, stack_sel, alu_start, retire, halted, fault_code.
  - Reset mid-WAIT or mid-STACK abandons the instruction; no retire pulse is generated.
- FETCH:
  - instr_ready = 1.
  - When instr_valid is high, ir <= instr and go to EXEC.
  - instr_valid is ignored in every other state.
- EXEC (cycle N+1 after acceptance):
  - alucode, imm_sel, reg_write, pc_ctrl and stack_sel are driven from ir.
  - ALU ops and MOV/MOVI: retire = 1, go to FETCH. Minimum throughput is 2 cycles per instruction.
  - MUL/MULI/DIV/DIVI/MOD with MULTICYCLE_ALU=1: alu_start = 1 for one cycle, go to WAIT. Control outputs are held.
  - PUSH/POP: go to STACK.
  - HLT: halted = 1, pc_ctrl = 10, go to HALT.
  - Opcode 30–63: fault_code = 3, pc_ctrl = 10, go to HALT.
- WAIT:
  - Outputs are held.
  - On alu_done: retire = 1, reg_write = 1 in that cycle only, go to FETCH.
  - alu_done outside WAIT is ignored.
- STACK:
  - PUSH with sp == STACK_DEPTH: fault_code = 1, go to HALT.
  - PUSH otherwise: stack_sel = 1, sp + 1, retire = 1.
  - POP with sp == 0: fault_code = 2, go to HALT.
  - POP otherwise: stack_sel = 2, sp − 1, reg_write = 1, retire = 1.
  - SP never wraps.
- HALT:
  - Terminal state; instr_ready = 0 and all outputs are frozen until reset.
- Decode table (opcode -> alucode, imm_sel):
  - ADD 0 / ADDI 4 -> 1
  - SUB 1 / SUBI 5 -> 2
  - MUL 2 / MULI 6 -> 3
  - DIV 3 / DIVI 7 -> 4
  - MOD 12 -> 5
  - OR 10 -> 6
  - AND 9 -> 7
  - NOT 8 -> 9
  - SR 14 -> 10
  - XOR 11 -> 11
  - SL 13 -> 12. SL no longer aliases XOR.
  - Jumps, MOV 24, MOVI 29 -> 14 (pass-through).
  - NOP 25 -> 0.
  - The I-forms and MOVI set imm_sel = 1.
- reg_write = 1 for all ALU ops and MOV/MOVI. It is 0 for jumps, NOP, PUSH and HLT.
- pc_ctrl:
  - JE 1, JB 2, JA 3, JNE 4, JBE 5, JAE 6, JNZ 7, JZ 8, JMP 9, halt 10.
  - 0 otherwise.
  - Driven only during the EXEC cycle, except that halt holds 10 while in HALT.
- op1/op2/flag/flag1 are combinational slices of ir and stay stable from EXEC until the next acceptance.

Decomposition:
- Package j17_pkg holds:
  - opcode localparams 0–29;
  - ALU code constants;
  - pc_ctrl codes;
  - fault codes;
  - state enum FETCH/EXEC/WAIT/STACK/HALT.
- Sub-module j17_decode: the combinational opcode -> {alucode, imm_sel, reg_write, pc_ctrl, class} decode. The FSM, ir and SP live in the top-level module.

Test Plan:
- ADDI r2,#5: instr = 0x1080_0005 with valid.
  - Cycle after acceptance: alucode = 1, imm_sel = 1, reg_write = 1, op1 = 2, op2 = 5, retire = 1.
  - instr_ready returns high on the next cycle.
- MUL: instr = 0x0800_0000.
  - alu_start pulses once; WAIT is held for 3 cycles.
  - alu_done arrives: retire and reg_write are high in the same cycle.
  - A spurious alu_done in FETCH has no effect.
- 16 PUSHes (0x6C00_0000), then a 17th PUSH:
  - sp reaches 16.
  - 17th PUSH: fault_code = 1, halted stays 0, instr_ready = 0, sp stays 16.
- Reset, then POP (0x7000_0000):
  - fault_code = 2, sp = 0.
- Illegal opcode: instr = 0xFC00_0000 -> fault_code = 3, pc_ctrl = 10.
- JZ (0x5800_0000): pc_ctrl = 8, reg_write = 0.
- HLT (0x6800_0000): halted = 1, pc_ctrl = 10.
- Assert reset during WAIT: next cycle state = FETCH, all outputs 0, sp = 0, no retire.
